riscv_dmem_arb: RTL and testbench
=================================

Name: riscv_dmem_arb

Overview:
Two-port arbiter and access sequencer in front of the single-port data memory. It shares the memory between the core load/store unit (port C) and a DMA/debug master (port D). Per cycle it grants at most one requester and translates byte address and size into the memory's word address, byte offset and byte-select. It checks alignment and returns registered read data or a write acknowledge one cycle after grant. The core has priority, bounded by a starvation counter that guarantees DMA progress.

Parameters:
STREAK_MAX, 4, max consecutive core grants while D is requesting before D is forced through (range 1..15)
AW, `DMEM_ADDR_BIT, byte-address width seen by requesters

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_c_req / i_d_req  in  1  request valid, held stable with its payload until granted
i_c_we / i_d_we  in  1  1 = store, 0 = load
i_c_addr / i_d_addr  in  AW  byte address
i_c_size / i_d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
i_c_unsigned / i_d_unsigned  in  1  zero-extend load
i_c_wdata / i_d_wdata  in  `XLEN  store data, right-aligned
o_c_gnt / o_d_gnt  out  1  combinational grant, request accepted this cycle
o_c_rvalid / o_d_rvalid  out  1  response valid, one cycle after grant
o_c_err / o_d_err  out  1  response is misaligned/reserved error, qualified by rvalid
o_rdata  out  `XLEN  registered load data, shared by both ports, qualified by each port's rvalid
o_dmem_addr  out  AW-2  word address = addr[AW-1:2]
o_dmem_byte_addr  out  2  addr[1:0]
o_dmem_byte_sel  out  4  byte 4'b0001, half 4'b0011, word 4'b1111
o_dmem_wr_en  out  1  memory write strobe
o_dmem_unsigned  out  1  unsigned-load select to memory
o_dmem_data  out  `XLEN  store data to memory
i_dmem_data  in  `XLEN  combinational, already extended read data from memory

Behaviour:
- Reset (async, i_rstn=0): rvalid/err both ports 0; o_rdata 0; streak counter 0. While in reset, grants are 0 and o_dmem_wr_en is 0. A response pending at reset assertion is dropped and never issued.
- Arbitration, combinational on current requests and streak:
  - Only one port requesting: grant it.
  - Both requesting: grant C, unless streak == STREAK_MAX, then grant D.
- Streak counter, 4-bit, updated on each clock:
  - C granted while i_d_req=1: streak+1.
  - D granted, or i_d_req=0: streak <= 0.
  - Never exceeds STREAK_MAX.
- Memory drive: addr, byte fields, wdata, unsigned and size come from the granted port, else from port C. o_dmem_wr_en = gnt & we & ~err.
  - o_dmem_unsigned is forced 0 for word size, because the memory has no unsigned word load.
  - When no grant: byte_sel 4'b1111, wr_en 0.
- Alignment error: size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3 always.
  - The error still consumes the grant.
  - No memory write occurs.
  - Response has err=1 and o_rdata 0.
- Response: in the cycle after a grant, the granted port's rvalid=1 for one cycle, for loads and stores alike.
  - Loads: o_rdata <= i_dmem_data sampled at the grant edge. It holds until the next load response.
  - Stores: o_rdata is unchanged.
- Throughput: one grant per cycle, back-to-back allowed. Either port may request again in the rvalid cycle.
- Read-after-write, same word in consecutive cycles: the load observes the stored value, because memory writes at the grant edge and the next grant reads combinationally.
- Simultaneous response and new grant to different ports is legal. At most one rvalid is high per cycle.

Test Plan:
1. Reset mid-operation: C load granted, i_rstn pulsed low before the next edge. -> o_c_rvalid stays 0, o_rdata=0, streak=0.
2. Store/load: C stores word 0xDEADBEEF at 0x10, then loads half at 0x12 with unsigned=1. -> o_dmem_byte_sel 4'b1111 then 4'b0011. The load response has o_rdata=0x0000DEAD, rvalid one cycle after each grant.
3. Byte sign: D stores byte 0x80 at 0x21, then loads byte at 0x21 with unsigned=0. -> o_rdata=0xFFFFFF80. Word 0x20 bytes 0, 2 and 3 are unchanged.
4. Misaligned access: C word store at 0x22 with wdata 0x12345678. -> granted, wr_en 0, next cycle o_c_rvalid=1 and o_c_err=1. A later load of 0x20 shows the old contents.
5. Starvation bound: both ports request continuously. -> grant pattern C,C,C,C,D repeating with STREAK_MAX=4. D dropping its request resets the streak.
6. Word unsigned: C loads word with unsigned=1. -> o_dmem_unsigned=0 and o_rdata equals the full stored word.

Source files
------------

// File: rtl/riscv_dmem_arb.sv
// Core/DMA arbiter and access sequencer for the single-port data memory.
// Latency: combinational grant; response (rvalid/err/rdata) registered one cycle after grant.
// Backpressure: a requester holds req+payload until gnt; core wins ties until the streak limit.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_ADDR_BIT
`define DMEM_ADDR_BIT 12
`endif

module riscv_dmem_arb #(
  parameter int STREAK_MAX = 4,
  parameter int AW         = `DMEM_ADDR_BIT
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [AW-1:0]     i_c_addr,
  input  logic [1:0]        i_c_size,
  input  logic              i_c_unsigned,
  input  logic [`XLEN-1:0]  i_c_wdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [AW-1:0]     i_d_addr,
  input  logic [1:0]        i_d_size,
  input  logic              i_d_unsigned,
  input  logic [`XLEN-1:0]  i_d_wdata,
  output logic              o_c_gnt,
  output logic              o_d_gnt,
  output logic              o_c_rvalid,
  output logic              o_d_rvalid,
  output logic              o_c_err,
  output logic              o_d_err,
  output logic [`XLEN-1:0]  o_rdata,
  output logic [AW-3:0]     o_dmem_addr,
  output logic [1:0]        o_dmem_byte_addr,
  output logic [3:0]        o_dmem_byte_sel,
  output logic              o_dmem_wr_en,
  output logic              o_dmem_unsigned,
  output logic [`XLEN-1:0]  o_dmem_data,
  input  logic [`XLEN-1:0]  i_dmem_data
);

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  typedef struct packed {
    logic              we;
    logic [AW-1:0]     addr;
    logic [1:0]        size;
    logic              uns;
    logic [`XLEN-1:0]  wdata;
  } req_t;

  req_t       c_req_dat;
  req_t       d_req_dat;
  req_t       sel;
  logic [3:0] streak;
  logic       c_gnt;
  logic       d_gnt;
  logic       any_gnt;
  logic       sel_err;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lo[0];
      2'd2:    misaligned = |lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

  assign c_req_dat = '{we: i_c_we, addr: i_c_addr, size: i_c_size, uns: i_c_unsigned, wdata: i_c_wdata};
  assign d_req_dat = '{we: i_d_we, addr: i_d_addr, size: i_d_size, uns: i_d_unsigned, wdata: i_d_wdata};

  // Grants are suppressed while reset is asserted so no write can slip through.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_rstn) begin
      if (i_c_req && i_d_req) begin
        if (streak == STREAK_LIM) d_gnt = 1'b1;
        else                      c_gnt = 1'b1;
      end else begin
        c_gnt = i_c_req;
        d_gnt = i_d_req;
      end
    end
  end

  assign any_gnt = c_gnt | d_gnt;
  assign sel     = d_gnt ? d_req_dat : c_req_dat;
  assign sel_err = any_gnt & misaligned(sel.size, sel.addr[1:0]);

  assign o_c_gnt          = c_gnt;
  assign o_d_gnt          = d_gnt;
  assign o_dmem_addr      = sel.addr[AW-1:2];
  assign o_dmem_byte_addr = sel.addr[1:0];
  assign o_dmem_data      = sel.wdata;
  // Memory has no unsigned word load, so the flag is meaningless for words.
  assign o_dmem_unsigned  = sel.uns & (sel.size != 2'd2);
  assign o_dmem_wr_en     = any_gnt & sel.we & ~sel_err;

  always_comb begin
    o_dmem_byte_sel = 4'b1111;
    if (any_gnt) begin
      case (sel.size)
        2'd0:    o_dmem_byte_sel = 4'b0001;
        2'd1:    o_dmem_byte_sel = 4'b0011;
        default: o_dmem_byte_sel = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      streak <= '0;
    end else if (c_gnt && i_d_req) begin
      streak <= (streak >= STREAK_LIM) ? STREAK_LIM : streak + 4'd1;
    end else begin
      streak <= '0;
    end
  end

  // Error responses clear rdata; store responses leave the last load data in place.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_c_rvalid <= 1'b0;
      o_d_rvalid <= 1'b0;
      o_c_err    <= 1'b0;
      o_d_err    <= 1'b0;
      o_rdata    <= '0;
    end else begin
      o_c_rvalid <= c_gnt;
      o_d_rvalid <= d_gnt;
      o_c_err    <= c_gnt & sel_err;
      o_d_err    <= d_gnt & sel_err;
      if (sel_err)
        o_rdata <= '0;
      else if (any_gnt && !sel.we)
        o_rdata <= i_dmem_data;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Directed bench for riscv_dmem_arb: memory model, scoreboard of expected responses,
// and a negedge monitor that pops and compares whenever an rvalid appears.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_dmem_arb;
  localparam int AW = 12;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_c_req = 1'b0, i_c_we = 1'b0, i_c_unsigned = 1'b0;
  logic [11:0] i_c_addr = '0;
  logic [1:0]  i_c_size = '0;
  logic [31:0] i_c_wdata = '0;
  logic        i_d_req = 1'b0, i_d_we = 1'b0, i_d_unsigned = 1'b0;
  logic [11:0] i_d_addr = '0;
  logic [1:0]  i_d_size = '0;
  logic [31:0] i_d_wdata = '0;
  logic        o_c_gnt, o_d_gnt, o_c_rvalid, o_d_rvalid, o_c_err, o_d_err;
  logic [31:0] o_rdata;
  logic [9:0]  o_dmem_addr;
  logic [1:0]  o_dmem_byte_addr;
  logic [3:0]  o_dmem_byte_sel;
  logic        o_dmem_wr_en, o_dmem_unsigned;
  logic [31:0] o_dmem_data;
  logic [31:0] i_dmem_data;

  riscv_dmem_arb #(.STREAK_MAX(4), .AW(AW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_c_req(i_c_req), .i_c_we(i_c_we), .i_c_addr(i_c_addr), .i_c_size(i_c_size),
    .i_c_unsigned(i_c_unsigned), .i_c_wdata(i_c_wdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_size(i_d_size),
    .i_d_unsigned(i_d_unsigned), .i_d_wdata(i_d_wdata),
    .o_c_gnt(o_c_gnt), .o_d_gnt(o_d_gnt), .o_c_rvalid(o_c_rvalid), .o_d_rvalid(o_d_rvalid),
    .o_c_err(o_c_err), .o_d_err(o_d_err), .o_rdata(o_rdata),
    .o_dmem_addr(o_dmem_addr), .o_dmem_byte_addr(o_dmem_byte_addr),
    .o_dmem_byte_sel(o_dmem_byte_sel), .o_dmem_wr_en(o_dmem_wr_en),
    .o_dmem_unsigned(o_dmem_unsigned), .o_dmem_data(o_dmem_data), .i_dmem_data(i_dmem_data)
  );

  initial forever #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: byte-lane writes at the clock edge, combinational extended read.
  logic [31:0] mem [0:1023];
  bit          mem_clr = 1'b0;
  always @(posedge i_clk) begin
    if (!mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem_clr <= 1'b1;
    end else if (o_dmem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (o_dmem_byte_sel[b])
          mem[o_dmem_addr][((b + 32'(o_dmem_byte_addr)) & 3) * 8 +: 8] <= o_dmem_data[b*8 +: 8];
    end
  end

  logic [31:0] rd_shift;
  always_comb begin
    rd_shift = mem[o_dmem_addr] >> (8 * 32'(o_dmem_byte_addr));
    case (o_dmem_byte_sel)
      4'b0001: i_dmem_data = o_dmem_unsigned ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      4'b0011: i_dmem_data = o_dmem_unsigned ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: i_dmem_data = rd_shift;
    endcase
  end

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_rd = '0;

  task automatic push_exp(input bit port, input bit we, input bit err, input logic [31:0] rd);
    exp_t e;
    e.port = port;
    e.err  = err;
    if (err)      last_rd = '0;
    else if (!we) last_rd = rd;
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_c_rvalid || o_d_rvalid) begin
        chk("one_rvalid", 32'(o_c_rvalid & o_d_rvalid), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: c_rvalid=%0b d_rvalid=%0b, no response expected", o_c_rvalid, o_d_rvalid);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", 32'(o_d_rvalid), 32'(e.port));
          chk("rsp_err", 32'(e.port ? o_d_err : o_c_err), 32'(e.err));
          chk("rsp_rdata", o_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drive(input bit port, input bit req, input bit we, input logic [11:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wdata);
    if (port) begin
      i_d_req = req; i_d_we = we; i_d_addr = addr; i_d_size = size; i_d_unsigned = uns; i_d_wdata = wdata;
    end else begin
      i_c_req = req; i_c_we = we; i_c_addr = addr; i_c_size = size; i_c_unsigned = uns; i_c_wdata = wdata;
    end
  endtask

  // Issue one request from one port; called at posedge+1, returns at posedge+1.
  task automatic do_req(input bit port, input bit we, input logic [11:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata, input bit exp_err,
                        input logic [31:0] exp_rd, input logic [3:0] exp_sel, input bit exp_uns);
    bit got = 1'b0;
    drive(port, 1'b1, we, addr, size, uns, wdata);
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge i_clk);
      if (port ? o_d_gnt : o_c_gnt) begin
        got = 1'b1;
        chk("dmem_addr", 32'(o_dmem_addr), 32'(addr[11:2]));
        chk("dmem_byte_addr", 32'(o_dmem_byte_addr), 32'(addr[1:0]));
        chk("dmem_byte_sel", 32'(o_dmem_byte_sel), 32'(exp_sel));
        chk("dmem_wr_en", 32'(o_dmem_wr_en), 32'(we & ~exp_err));
        chk("dmem_unsigned", 32'(o_dmem_unsigned), 32'(exp_uns));
        if (we && !exp_err) chk("dmem_data", o_dmem_data, wdata);
        push_exp(port, we, exp_err, exp_rd);
      end
      @(posedge i_clk);
      #1;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    drive(port, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);
  endtask

  bit dreq_pat [13] = '{1,1,1,1,1,1,1,0,1,1,1,1,1};
  bit dgnt_exp [13] = '{0,0,0,0,1,0,0,0,0,0,0,0,1};

  initial begin
    // Reset state, with a request held during reset
    repeat (2) @(posedge i_clk);
    #1;
    drive(1'b0, 1'b1, 1'b1, 12'h010, 2'd2, 1'b0, 32'hCAFE0000);
    @(negedge i_clk);
    chk("rst_c_gnt", 32'(o_c_gnt), 32'd0);
    chk("rst_wr_en", 32'(o_dmem_wr_en), 32'd0);
    chk("rst_c_rvalid", 32'(o_c_rvalid), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Store word then back-to-back half load (read-after-write)
    do_req(1'b0, 1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 4'b1111, 1'b0);
    do_req(1'b0, 1'b0, 12'h012, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0000DEAD, 4'b0011, 1'b1);
    // Byte store into a preloaded word, signed byte load, word read-back
    do_req(1'b1, 1'b1, 12'h020, 2'd2, 1'b0, 32'h11223344, 1'b0, 32'h0, 4'b1111, 1'b0);
    do_req(1'b1, 1'b1, 12'h021, 2'd0, 1'b0, 32'hAAAAAA80, 1'b0, 32'h0, 4'b0001, 1'b0);
    do_req(1'b1, 1'b0, 12'h021, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80, 4'b0001, 1'b0);
    do_req(1'b1, 1'b0, 12'h020, 2'd2, 1'b0, 32'h0, 1'b0, 32'h11228044, 4'b1111, 1'b0);
    // Misaligned and reserved-size accesses
    do_req(1'b0, 1'b1, 12'h022, 2'd2, 1'b0, 32'h12345678, 1'b1, 32'h0, 4'b1111, 1'b0);
    do_req(1'b0, 1'b0, 12'h020, 2'd2, 1'b0, 32'h0, 1'b0, 32'h11228044, 4'b1111, 1'b0);
    do_req(1'b0, 1'b0, 12'h021, 2'd1, 1'b1, 32'h0, 1'b1, 32'h0, 4'b0011, 1'b1);
    do_req(1'b1, 1'b0, 12'h024, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 4'b1111, 1'b0);
    // Unsigned word load: flag forced off, full word returned
    do_req(1'b0, 1'b0, 12'h010, 2'd2, 1'b1, 32'h0, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b0);

    // Reset mid-operation: granted load's response is dropped, streak cleared
    @(posedge i_clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 2'd2, 1'b0, 32'h0);
    @(negedge i_clk);
    chk("pre_rst_c_gnt", 32'(o_c_gnt), 32'd1);
    #2 i_rstn = 1'b0;
    last_rd = '0;
    @(negedge i_clk);
    chk("midrst_c_rvalid", 32'(o_c_rvalid), 32'd0);
    chk("midrst_d_rvalid", 32'(o_d_rvalid), 32'd0);
    chk("midrst_rdata", o_rdata, 32'd0);
    chk("midrst_gnt", 32'({o_c_gnt, o_d_gnt}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);
    #1 i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Starvation bound: C,C,C,C,D; D dropping its request clears the streak
    drive(1'b0, 1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 2'd2, 1'b0, 32'h0);
    for (int k = 0; k < 13; k++) begin
      i_d_req = dreq_pat[k];
      @(negedge i_clk);
      chk($sformatf("streak_c_gnt[%0d]", k), 32'(o_c_gnt), 32'(!dgnt_exp[k]));
      chk($sformatf("streak_d_gnt[%0d]", k), 32'(o_d_gnt), 32'(dgnt_exp[k]));
      push_exp(dgnt_exp[k], 1'b0, 1'b0, dgnt_exp[k] ? 32'h11228044 : 32'hDEADBEEF);
      @(posedge i_clk);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge i_clk);
    repeat (2) @(posedge i_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
